// File: rtl/fp32_pkg.sv
// Shared binary32 field layout, special encodings and sequencer state type
// for the fp32 multiplier.
package fp32_pkg;

  localparam int SIGN_W   = 1;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int MANT_W   = FRAC_W + 1;
  localparam int PROD_W   = 2 * MANT_W;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    SPECIAL,
    MULTIPLY,
    NORMALISE,
    ROUND,
    PACK,
    OUTPUT
  } fp32_mul_state_t;

endpackage

// File: rtl/fp32_round_pack.sv
// Combinational round-to-nearest-even and pack of a normalised 48-bit product
// (leading one at bit 46) into a binary32 word, with overflow/underflow flush.
module fp32_round_pack
  import fp32_pkg::*;
(
  input  logic                    sign,
  input  logic signed [9:0]       exp_in,
  input  logic [PROD_W-1:0]       prod,
  input  logic                    guard,
  input  logic                    sticky,
  output logic [31:0]             z,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    inexact
);

  localparam logic signed [9:0] EXP_TOP = 10'(EXP_MAX);

  function automatic logic [MANT_W:0] round_rne(input logic [MANT_W-1:0] mant,
                                                input logic g, input logic s);
    return {1'b0, mant} + {{MANT_W{1'b0}}, g & (s | mant[0])};
  endfunction

  // Returns {overflow, underflow, packed word}.
  function automatic logic [33:0] saturate_pack(input logic sgn,
                                                input logic signed [9:0] e,
                                                input logic [FRAC_W-1:0] frac);
    if (e >= EXP_TOP)
      return {2'b10, sgn, POS_INF[30:0]};
    else if (e <= 10'sd0)
      return {2'b01, sgn, 31'd0};
    else
      return {2'b00, sgn, e[7:0], frac};
  endfunction

  logic [MANT_W:0]    mant_r;
  logic signed [9:0]  exp_r;
  logic               unused_bits;

  always_comb begin
    mant_r = round_rne(prod[PROD_W-2 -: MANT_W], guard, sticky);
    exp_r  = exp_in;
    // A carry out of the mantissa leaves the low 23 bits zero, i.e. 1.0 x 2^(e+1).
    if (mant_r[MANT_W])
      exp_r = exp_in + 10'sd1;
    {overflow, underflow, z} = saturate_pack(sign, exp_r, mant_r[FRAC_W-1:0]);
    inexact = guard | sticky | overflow | underflow;
  end

  assign unused_bits = ^{prod[PROD_W-1], prod[FRAC_W-1:0], mant_r[FRAC_W]};

endmodule

// File: rtl/fp32_mul_seq.sv
// Multi-cycle binary32 multiplier sequencer with valid/ready on both sides.
// Optional build macro FP32_MUL_STATUS_EN adds the 4-bit status output.
module fp32_mul_seq
  import fp32_pkg::*;
#(
  parameter logic [31:0] CANON_NAN = QNAN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] output_z,
  output logic        out_valid,
  input  logic        out_ready
`ifdef FP32_MUL_STATUS_EN
  ,
  output logic [3:0]  status
`endif
);

  fp32_mul_state_t     state;

  logic [31:0]         a_p0, b_p0;
  logic                sign_a_p1, sign_b_p1;
  logic [EXP_W-1:0]    exp_a_p1, exp_b_p1;
  logic [FRAC_W-1:0]   frac_a_p1, frac_b_p1;
  logic [MANT_W-1:0]   mant_a_p1, mant_b_p1;
  logic                sign_z_p1;
  logic [PROD_W-1:0]   prod_p2, prod_p3;
  logic signed [9:0]   exp_p2, exp_p3;
  logic                guard_p3, sticky_p3;
  logic [31:0]         z_p4;

  logic                nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic                nan_res, inf_res, zero_res, sign_z;

  logic [31:0]         rp_z;
  logic                rp_ovf, rp_udf, rp_inx;

`ifdef FP32_MUL_STATUS_EN
  logic                sub_any;
  logic                ovf_p4, udf_p4, inx_p4;
`else
  logic                unused_rp_flags;
  assign unused_rp_flags = ^{rp_ovf, rp_udf, rp_inx};
`endif

  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  always_comb begin
    nan_a    = (exp_a_p1 == EXP_ONES) && (frac_a_p1 != '0);
    nan_b    = (exp_b_p1 == EXP_ONES) && (frac_b_p1 != '0);
    inf_a    = (exp_a_p1 == EXP_ONES) && (frac_a_p1 == '0);
    inf_b    = (exp_b_p1 == EXP_ONES) && (frac_b_p1 == '0);
    // Subnormals are flushed: any zero exponent counts as zero.
    zero_a   = (exp_a_p1 == '0);
    zero_b   = (exp_b_p1 == '0);
    nan_res  = nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a);
    inf_res  = inf_a | inf_b;
    zero_res = zero_a | zero_b;
    sign_z   = sign_a_p1 ^ sign_b_p1;
  end

`ifdef FP32_MUL_STATUS_EN
  assign sub_any = (zero_a && (frac_a_p1 != '0)) || (zero_b && (frac_b_p1 != '0));
`endif

  fp32_round_pack u_round_pack (
    .sign      (sign_z_p1),
    .exp_in    (exp_p3),
    .prod      (prod_p3),
    .guard     (guard_p3),
    .sticky    (sticky_p3),
    .z         (rp_z),
    .overflow  (rp_ovf),
    .underflow (rp_udf),
    .inexact   (rp_inx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      output_z  <= '0;
      a_p0      <= '0;
      b_p0      <= '0;
      sign_a_p1 <= 1'b0;
      sign_b_p1 <= 1'b0;
      exp_a_p1  <= '0;
      exp_b_p1  <= '0;
      frac_a_p1 <= '0;
      frac_b_p1 <= '0;
      mant_a_p1 <= '0;
      mant_b_p1 <= '0;
      sign_z_p1 <= 1'b0;
      prod_p2   <= '0;
      prod_p3   <= '0;
      exp_p2    <= '0;
      exp_p3    <= '0;
      guard_p3  <= 1'b0;
      sticky_p3 <= 1'b0;
      z_p4      <= '0;
`ifdef FP32_MUL_STATUS_EN
      ovf_p4    <= 1'b0;
      udf_p4    <= 1'b0;
      inx_p4    <= 1'b0;
      status    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_p0     <= input_a;
            b_p0     <= input_b;
            in_ready <= 1'b0;
            state    <= UNPACK;
          end
        end

        // ---- unpack: split fields, build hidden-bit mantissas ----
        UNPACK: begin
          sign_a_p1 <= a_p0[31];
          sign_b_p1 <= b_p0[31];
          exp_a_p1  <= a_p0[30:23];
          exp_b_p1  <= b_p0[30:23];
          frac_a_p1 <= a_p0[22:0];
          frac_b_p1 <= b_p0[22:0];
          mant_a_p1 <= (a_p0[30:23] != '0) ? {1'b1, a_p0[22:0]} : '0;
          mant_b_p1 <= (b_p0[30:23] != '0) ? {1'b1, b_p0[22:0]} : '0;
          state     <= SPECIAL;
        end

        // ---- special: NaN / inf / zero short-circuit to OUTPUT ----
        SPECIAL: begin
          sign_z_p1 <= sign_z;
          if (nan_res || inf_res || zero_res) begin
            if (nan_res)
              output_z <= CANON_NAN;
            else if (inf_res)
              output_z <= {sign_z, POS_INF[30:0]};
            else
              output_z <= {sign_z, 31'd0};
`ifdef FP32_MUL_STATUS_EN
            status <= {nan_res, 1'b0, sub_any, sub_any};
`endif
            out_valid <= 1'b1;
            state     <= OUTPUT;
          end else begin
            state <= MULTIPLY;
          end
        end

        // ---- multiply: full 24x24 product and unbiased exponent sum ----
        MULTIPLY: begin
          prod_p2 <= {{MANT_W{1'b0}}, mant_a_p1} * {{MANT_W{1'b0}}, mant_b_p1};
          exp_p2  <= $signed({2'b00, exp_a_p1}) + $signed({2'b00, exp_b_p1})
                     - $signed(10'(EXP_BIAS));
          state   <= NORMALISE;
        end

        // ---- normalise: leading one to bit 46, collect guard/sticky ----
        NORMALISE: begin
          if (prod_p2[PROD_W-1]) begin
            prod_p3   <= {1'b0, prod_p2[PROD_W-1:1]};
            exp_p3    <= exp_p2 + 10'sd1;
            guard_p3  <= prod_p2[FRAC_W];
            sticky_p3 <= |prod_p2[FRAC_W-1:0];
          end else begin
            prod_p3   <= prod_p2;
            exp_p3    <= exp_p2;
            guard_p3  <= prod_p2[FRAC_W-1];
            sticky_p3 <= |prod_p2[FRAC_W-2:0];
          end
          state <= ROUND;
        end

        // ---- round: capture the combinational round/pack result ----
        ROUND: begin
          z_p4 <= rp_z;
`ifdef FP32_MUL_STATUS_EN
          ovf_p4 <= rp_ovf;
          udf_p4 <= rp_udf;
          inx_p4 <= rp_inx;
`endif
          state <= PACK;
        end

        // ---- pack: publish the result ----
        PACK: begin
          output_z  <= z_p4;
`ifdef FP32_MUL_STATUS_EN
          status    <= {1'b0, ovf_p4, udf_p4, inx_p4};
`endif
          out_valid <= 1'b1;
          state     <= OUTPUT;
        end

        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_mul_seq.sv
// Scoreboard bench for fp32_mul_seq: driver pushes model results, a negedge
// monitor pops and compares on every output handoff.
module tb_fp32_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = '0;
  logic [31:0] input_b = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] output_z;
  logic        out_valid;
  logic        out_ready = 1'b1;
`ifdef FP32_MUL_STATUS_EN
  logic [3:0]  status;
`endif

  fp32_mul_seq dut (
    .clk       (clk),
    .rst       (rst),
    .input_a   (input_a),
    .input_b   (input_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .output_z  (output_z),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FP32_MUL_STATUS_EN
    ,
    .status    (status)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic [3:0]  st;
    int          acc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rand_ready = 1'b0;
  logic forced_ready = 1'b1;
  bit   seen_valid = 1'b0;
  int   first_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: exact integer product, generic RNE to 24 bits, FTZ on both ends.
  function automatic exp_t ref_mul(input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    logic sz, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, sub, inexact;
    int ea, eb, k, sh, e_res;
    logic [22:0] fa, fb;
    longint unsigned p, q, rem, half;
    r.a = a; r.b = b; r.acc = 0; r.st = 4'b0000; r.z = '0; r.lat = 2;
    sz = a[31] ^ b[31];
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = a[22:0]; fb = b[22:0];
    nan_a = (ea == 255) && (fa != 0); nan_b = (eb == 255) && (fb != 0);
    inf_a = (ea == 255) && (fa == 0); inf_b = (eb == 255) && (fb == 0);
    zero_a = (ea == 0); zero_b = (eb == 0);
    sub = (zero_a && fa != 0) || (zero_b && fb != 0);
    if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
      r.z = 32'h7FC0_0000; r.st = {1'b1, 1'b0, sub, sub};
    end else if (inf_a || inf_b) begin
      r.z = {sz, 8'hFF, 23'd0}; r.st = {2'b00, sub, sub};
    end else if (zero_a || zero_b) begin
      r.z = {sz, 31'd0}; r.st = {2'b00, sub, sub};
    end else begin
      r.lat = 6;
      p = 64'({1'b1, fa}) * 64'({1'b1, fb});
      k = 0;
      for (int i = 0; i < 64; i++) if (p[i]) k = i;
      sh = k - 23;
      q = p >> sh;
      rem = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      e_res = k + ea + eb - 300 + 127;
      inexact = (rem != 0);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin q = q >> 1; e_res++; end
      if (e_res >= 255) begin
        r.z = {sz, 8'hFF, 23'd0}; r.st = 4'b0101;
      end else if (e_res <= 0) begin
        r.z = {sz, 31'd0}; r.st = 4'b0011;
      end else begin
        r.z = {sz, e_res[7:0], q[22:0]}; r.st = {3'b000, inexact};
      end
    end
    return r;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit expect_out);
    int n;
    exp_t e;
    input_a = a; input_b = b; in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, n);
    end else if (expect_out) begin
      e = ref_mul(a, b);
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen_valid = 1'b0;
    end else begin
      if (out_valid && !seen_valid) begin
        seen_valid = 1'b1;
        first_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        seen_valid = 1'b0;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got z=%h, expected no output", output_z);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("z(%h*%h)", e.a, e.b), output_z, e.z);
          check($sformatf("latency(%h*%h)", e.a, e.b), 32'(first_cyc - e.acc), 32'(e.lat));
`ifdef FP32_MUL_STATUS_EN
          check($sformatf("status(%h*%h)", e.a, e.b), {28'd0, status}, {28'd0, e.st});
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b, zhold;
    logic [31:0] specials [8];
    int mode, ea, eb, n;
    specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                 32'h7FC0_0001, 32'h0000_0001, 32'h007F_FFFF, 32'h3F80_0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_output_z", output_z, 32'd0);
`ifdef FP32_MUL_STATUS_EN
    check("reset_status", {28'd0, status}, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    send(32'h4000_0000, 32'h4040_0000, 1'b1);
    send(32'hC000_0000, 32'h4040_0000, 1'b1);
    send(32'h3FC0_0000, 32'h3FC0_0000, 1'b1);
    send(32'h7F80_0000, 32'h0000_0000, 1'b1);
    send(32'h7F80_0000, 32'hBF80_0000, 1'b1);
    send(32'h7F7F_FFFF, 32'h4000_0000, 1'b1);
    send(32'h0080_0000, 32'h3F00_0000, 1'b1);
    send(32'h7FC0_0001, 32'h3F80_0000, 1'b1);
    send(32'h0000_0001, 32'hC000_0000, 1'b1);
    send(32'h3F80_0001, 32'h3F80_0001, 1'b1);
    drain();

    // Back-pressure: result must hold and junk operands must be ignored.
    forced_ready = 1'b0;
    send(32'h4040_0000, 32'h40A0_0000, 1'b1);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 20);
    check("bp_valid_seen", {31'd0, out_valid}, 32'd1);
    zhold = output_z;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      input_a = $urandom; input_b = $urandom; in_valid = 1'b1;
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_output_z", output_z, zhold);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    forced_ready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (out_valid && n < 10);
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    drain();

    // Reset while the operation sits in MULTIPLY (third cycle after accept).
    send(32'h4000_0000, 32'h4040_0000, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_output_z", output_z, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    rand_ready = 1'b1;
    for (int t = 0; t < 80; t++) begin
      mode = $urandom_range(0, 4);
      case (mode)
        0: begin a = $urandom; b = $urandom; end
        1: begin
          ea = $urandom_range(100, 154); eb = $urandom_range(100, 154);
          a = {1'($urandom), 8'(ea), 23'($urandom)};
          b = {1'($urandom), 8'(eb), 23'($urandom)};
        end
        2: begin
          ea = $urandom_range(1, 126); eb = 127 - ea + $urandom_range(0, 2);
          a = {1'($urandom), 8'(ea), 23'($urandom)};
          b = {1'($urandom), 8'(eb), 23'($urandom)};
        end
        3: begin
          ea = $urandom_range(130, 254); eb = 381 - ea - $urandom_range(0, 2);
          a = {1'($urandom), 8'(ea), 23'($urandom)};
          b = {1'($urandom), 8'(eb), 23'($urandom)};
        end
        default: begin
          a = specials[$urandom_range(0, 7)];
          b = $urandom;
        end
      endcase
      send(a, b, 1'b1);
    end
    rand_ready = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
